regfile_mp: RTL

//  Parametrised multi-port CPU register file; successor to the 2R/1W file.

---
 rtl/regfile_mp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with self-timed clear sweep
//
// Purpose: 2-write / NRD-read CPU register file with registered reads,
// optional write-first bypass, optional hardwired-zero entry 0, and a clear
// sequencer that zeroes every entry after reset or on clr_req.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   we0/waddr0/wdata0  write port 0
//   we1/waddr1/wdata1  write port 1 (wins over port 0 on the same address)
//   clr_req            start a full clear (sampled only when not busy)
//   raddr              NRD read addresses, port k at [k*AW +: AW]
//   rdata              NRD registered read data, port k at [k*DW +: DW]
//   busy               high while the clear sweep runs
module regfile_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic              clr_req,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic              busy
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  // One bit wider than an address so the terminal compare sees DEPTH-1
  // before any wrap could occur.
  logic [AW:0]         clr_idx_q, clr_idx_d;
  logic [NRD*DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]       mem_q [DEPTH];

  logic                ready;
  logic                w0_en, w1_en;

  assign ready = (state_q == ST_READY);

  // Writes are only accepted in READY; entry 0 is read-only when hardwired.
  assign w0_en = we0 && ready && !((ZERO_R0 != 0) && (waddr0 == '0));
  assign w1_en = we1 && ready && !((ZERO_R0 != 0) && (waddr1 == '0));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_READY;
        end
      end
      default: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    logic [AW-1:0] a;
    rdata_d = '0;
    for (int k = 0; k < NRD; k++) begin
      a = raddr[k*AW +: AW];
      if (!ready || ((ZERO_R0 != 0) && (a == '0))) begin
        rdata_d[k*DW +: DW] = '0;
      end else if ((BYPASS != 0) && w1_en && (waddr1 == a)) begin
        rdata_d[k*DW +: DW] = wdata1;
      end else if ((BYPASS != 0) && w0_en && (waddr0 == a)) begin
        rdata_d[k*DW +: DW] = wdata0;
      end else begin
        rdata_d[k*DW +: DW] = mem_q[a];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage has no reset; the sweep zeroes it. Port 1 is written last so it
  // wins when both ports target the same entry.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[clr_idx_q[AW-1:0]] <= '0;
    end
    if (w0_en) begin
      mem_q[waddr0] <= wdata0;
    end
    if (w1_en) begin
      mem_q[waddr1] <= wdata1;
    end
  end

  assign rdata = rdata_q;
  assign busy  = !ready;

endmodule
